capture_probe: RTL and testbench

- Parametrised on-chip capture core that replaces the fixed-width, single-trigger analyzer probe in the equalizer debug path.
- Samples an arbitrary-width probe bus into a circular buffer and holds a programmable number of pre-trigger samples.
- Trigger is selectable: level, rising edge, falling edge or immediate.
- Stops after the buffer holds DEPTH samples aligned around the trigger, then exposes the result through a registered random-access readout port for a host/UART bridge.

---
 rtl/capture_probe_if.sv | 31 +++
 rtl/capture_probe.sv | 109 ++++++++++
 tb/tb_capture_probe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/capture_probe_if.sv
// capture_probe_if: probe, control, status and readout signals of capture_probe.
//   master: host/bench side. It drives the probe bus, the controls and rd_req/rd_idx.
//   slave : capture core side. It drives rd_data, rd_valid, state_o, done and trig_pos.
interface capture_probe_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] data_i;
    logic              trig_i;
    logic              sample_en;
    logic              arm;
    logic              abort;
    logic [AW-1:0]     pre_count;
    logic [1:0]        trig_mode;
    logic              rd_req;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [2:0]        state_o;
    logic              done;
    logic [AW-1:0]     trig_pos;
    modport master (
        output data_i, trig_i, sample_en, arm, abort, pre_count, trig_mode, rd_req, rd_idx,
        input  rd_data, rd_valid, state_o, done, trig_pos
    );
    modport slave (
        input  data_i, trig_i, sample_en, arm, abort, pre_count, trig_mode, rd_req, rd_idx,
        output rd_data, rd_valid, state_o, done, trig_pos
    );
endinterface

// File: rtl/capture_probe.sv
// capture_probe: circular-buffer capture of a probe bus around a selectable trigger.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : capture_probe_if slave
//     data_i/trig_i/sample_en : probe data, trigger source, sample strobe
//     arm/abort               : start capture, cancel capture
//     pre_count/trig_mode     : pre-trigger depth and trigger type, both latched on arm
//     rd_req/rd_idx           : readout request and index (0 = oldest sample)
//     rd_data/rd_valid        : registered readout result, valid one cycle after rd_req
//     state_o/done/trig_pos   : FSM state, capture complete, buffer address of the trigger
module capture_probe #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    capture_probe_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, pre_cnt, post_cnt, pre_l, trig_pos;
    logic [1:0]        mode_l;
    logic              trig_d, done, rd_valid, hit, we;
    logic [DATA_W-1:0] rd_data;
    logic [AW-1:0]     rd_addr;

    assign we = bus.sample_en && (state == PRE || state == WAIT || state == POST);
    assign hit = mode_l == 2'b11 ? 1'b1 :
                 mode_l == 2'b10 ? (~bus.trig_i & trig_d) :
                 mode_l == 2'b01 ? (bus.trig_i & ~trig_d) : bus.trig_i;
    // The pre-trigger window starts pre_count samples before the trigger and wraps mod DEPTH.
    assign rd_addr = trig_pos - pre_l + bus.rd_idx;

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.state_o  = state;
    assign bus.done     = done;
    assign bus.trig_pos = trig_pos;

    // The RAM has no reset, so a block RAM can be inferred.
    always_ff @(posedge clk)
        if (we) mem[wr_ptr] <= bus.data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            pre_l    <= '0;
            mode_l   <= '0;
            trig_d   <= 1'b0;
            trig_pos <= '0;
            done     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == DONE && bus.rd_req) begin
                rd_data  <= mem[rd_addr];
                rd_valid <= 1'b1;
            end
            if (bus.abort) begin
                state <= IDLE;
                done  <= 1'b0;
            end else if (state == IDLE || state == DONE) begin
                if (bus.arm) begin
                    wr_ptr  <= '0;
                    pre_cnt <= '0;
                    done    <= 1'b0;
                    trig_d  <= 1'b0;
                    pre_l   <= bus.pre_count;
                    mode_l  <= bus.trig_mode;
                    state   <= bus.pre_count == '0 ? WAIT : PRE;
                end
            end else if (bus.sample_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                trig_d <= bus.trig_i;
                case (state)
                    PRE: begin
                        pre_cnt <= pre_cnt + 1'b1;
                        if (pre_cnt + 1'b1 == pre_l) state <= WAIT;
                    end
                    WAIT: if (hit) begin
                        trig_pos <= wr_ptr;
                        post_cnt <= '0;
                        // A full pre-trigger window needs no post-trigger samples.
                        if (pre_l == LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else state <= POST;
                    end
                    POST: begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt + 1'b1 == LAST - pre_l) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_capture_probe.sv
// tb_capture_probe: directed self-checking bench for capture_probe (DATA_W=8, DEPTH=16).
module tb_capture_probe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    capture_probe_if #(.DATA_W(8), .DEPTH(16)) bus ();
    capture_probe #(.DATA_W(8), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm_cap(input logic [3:0] pc, input logic [1:0] mode);
        bus.pre_count = pc;
        bus.trig_mode = mode;
        bus.arm = 1'b1;
        tick;
        bus.arm = 1'b0;
    endtask

    task automatic smp(input logic [7:0] d, input logic t);
        bus.data_i = d;
        bus.trig_i = t;
        bus.sample_en = 1'b1;
        tick;
        bus.sample_en = 1'b0;
    endtask

    // Back-to-back reads of all 16 entries; entry i must hold base+i.
    task automatic read_seq(input string tag, input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            bus.rd_req = 1'b1;
            bus.rd_idx = 4'(i);
            tick;
            chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
            chk({tag, "_data"}, 32'(bus.rd_data), 32'(8'(base + 8'(i))));
        end
        bus.rd_req = 1'b0;
        tick;
        chk({tag, "_valid_low"}, 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic read_one(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        bus.rd_req = 1'b1;
        bus.rd_idx = idx;
        tick;
        bus.rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        bus.data_i = '0;
        bus.trig_i = 1'b0;
        bus.sample_en = 1'b0;
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        bus.pre_count = '0;
        bus.trig_mode = '0;
        bus.rd_req = 1'b0;
        bus.rd_idx = '0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_data", 32'(bus.rd_data), 32'd0);
        chk("rst_trigpos", 32'(bus.trig_pos), 32'd0);

        // 1: rising edge, pre_count 4, trigger at sample 10
        arm_cap(4'd4, 2'b01);
        chk("t1_pre", 32'(bus.state_o), 32'd1);
        for (int k = 0; k < 22; k++) begin
            smp(8'(k), k >= 10);
            if (k == 9) chk("t1_wait", 32'(bus.state_o), 32'd2);
            if (k == 10) chk("t1_post", 32'(bus.state_o), 32'd3);
            if (k == 20) chk("t1_notdone", 32'(bus.done), 32'd0);
        end
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_state", 32'(bus.state_o), 32'd4);
        chk("t1_trigpos", 32'(bus.trig_pos), 32'd10);
        read_seq("t1_rd", 8'd6);

        // 2: level trigger held high through PRE, pre_count 8
        arm_cap(4'd8, 2'b00);
        for (int k = 0; k < 16; k++) begin
            smp(8'(8'h40 + k), 1'b1);
            if (k == 7) chk("t2_wait", 32'(bus.state_o), 32'd2);
            if (k == 8) chk("t2_post", 32'(bus.state_o), 32'd3);
        end
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_trigpos", 32'(bus.trig_pos), 32'd8);
        read_one("t2_idx8", 4'd8, 8'h48);
        read_one("t2_idx0", 4'd0, 8'h40);
        read_one("t2_idx15", 4'd15, 8'h4F);

        // 3: immediate, pre_count 0, strobe every other cycle
        arm_cap(4'd0, 2'b11);
        chk("t3_wait", 32'(bus.state_o), 32'd2);
        for (int c = 0; c < 32; c++) begin
            bus.sample_en = (c % 2 == 0);
            bus.data_i = (c % 2 == 0) ? 8'(8'h80 + c / 2) : 8'hEE;
            tick;
            if (c == 29) chk("t3_notdone", 32'(bus.done), 32'd0);
            if (c == 30) chk("t3_done", 32'(bus.done), 32'd1);
        end
        bus.sample_en = 1'b0;
        chk("t3_trigpos", 32'(bus.trig_pos), 32'd0);
        read_seq("t3_rd", 8'h80);

        // 4: falling edge after 40 samples, pre_count 15 (done on trigger)
        arm_cap(4'd15, 2'b10);
        for (int k = 0; k < 41; k++) begin
            smp(8'(k), k < 40);
            if (k == 39) chk("t4_wait", 32'(bus.state_o), 32'd2);
        end
        chk("t4_state", 32'(bus.state_o), 32'd4);
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_trigpos", 32'(bus.trig_pos), 32'd8);
        read_seq("t4_rd", 8'd25);

        // 6: re-arm from DONE with pre_count 2
        arm_cap(4'd2, 2'b11);
        chk("t6_done_drop", 32'(bus.done), 32'd0);
        chk("t6_pre", 32'(bus.state_o), 32'd1);
        for (int k = 0; k < 16; k++) begin
            smp(8'(8'hC0 + k), 1'b0);
            if (k == 1) chk("t6_wait", 32'(bus.state_o), 32'd2);
            if (k == 14) chk("t6_notdone", 32'(bus.done), 32'd0);
        end
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_trigpos", 32'(bus.trig_pos), 32'd2);
        read_one("t6_idx0", 4'd0, 8'hC0);
        read_one("t6_idx2", 4'd2, 8'hC2);

        // 5: abort in POST, reset in WAIT, arm+abort together
        arm_cap(4'd0, 2'b11);
        for (int k = 0; k < 3; k++) smp(8'(k), 1'b0);
        chk("t5_post", 32'(bus.state_o), 32'd3);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("t5_abort_state", 32'(bus.state_o), 32'd0);
        chk("t5_abort_done", 32'(bus.done), 32'd0);
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
        chk("t5_idle_valid", 32'(bus.rd_valid), 32'd0);
        chk("t5_idle_hold", 32'(bus.rd_data), 32'hC2);
        arm_cap(4'd0, 2'b00);
        for (int k = 0; k < 3; k++) smp(8'(k), 1'b0);
        chk("t5_wait", 32'(bus.state_o), 32'd2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_rst_state", 32'(bus.state_o), 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        chk("t5_rst_data", 32'(bus.rd_data), 32'd0);
        chk("t5_rst_trigpos", 32'(bus.trig_pos), 32'd0);
        bus.abort = 1'b1;
        arm_cap(4'd3, 2'b01);
        bus.abort = 1'b0;
        chk("t5_armabort", 32'(bus.state_o), 32'd0);
        chk("t5_armabort_done", 32'(bus.done), 32'd0);
        bus.rd_req = 1'b1;
        tick;
        bus.rd_req = 1'b0;
        chk("t5_final_valid", 32'(bus.rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
